// File: rtl/alu_share_arb_if.sv
// Request/ALU/response bundle for alu_share_arb.
// slave  : arbiter side (takes requests and ALU result, drives ALU operands and response).
// master : issue-logic / consumer / ALU side.
// Ports  : req_valid/ready/instr/a/b per requester, alu_instr/a/b/result, rsp_valid/ready/id/data/err.
interface alu_share_arb_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [32*NREQ-1:0] req_instr_i;
  logic [64*NREQ-1:0] req_a_i;
  logic [64*NREQ-1:0] req_b_i;
  logic [31:0]        alu_instr_o;
  logic [63:0]        alu_a_o;
  logic [63:0]        alu_b_o;
  logic [63:0]        alu_result_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [IDW-1:0]     rsp_id_o;
  logic [63:0]        rsp_data_o;
  logic               rsp_err_o;

  modport slave (
    input  req_valid_i, req_instr_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    output req_ready_o, alu_instr_o, alu_a_o, alu_b_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_instr_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    input  req_ready_o, alu_instr_o, alu_a_o, alu_b_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one integer ALU among NREQ requesters.
// Two-stage pipe: S1 registers the granted operation onto the ALU inputs,
// S2 captures the ALU result with the requester tag and returns it on rsp_*.
// Ports: clk_i, rsn_i (synchronous, active-high reset), bus (alu_share_arb_if.slave).
module alu_share_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic           clk_i,
  input  logic           rsn_i,
  alu_share_arb_if.slave bus
);
  localparam int unsigned IW = 32;
  localparam int unsigned DW = 64;
  localparam logic [6:0]    OP_REG    = 7'b0110011;
  localparam logic [6:0]    OP_IMM    = 7'b0010011;
  localparam logic [IW-1:0] NOP_INSTR = 32'h00000013;

  logic           s1_v_q, s1_v_d;
  logic [IW-1:0]  s1_instr_q, s1_instr_d;
  logic [DW-1:0]  s1_a_q, s1_a_d;
  logic [DW-1:0]  s1_b_q, s1_b_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           s2_v_q, s2_v_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;
  logic [DW-1:0]  s2_data_q, s2_data_d;
  logic           s2_err_q, s2_err_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           s2_free, s1_adv, s1_free, s2_adv, s1_err;
  logic           found, accept;
  logic [IDW-1:0] gnt;
  logic [NREQ-1:0] ready;
  logic [IW-1:0]  sel_instr;
  logic [DW-1:0]  sel_a, sel_b;

  // Pipeline advance conditions
  assign s2_adv  = s2_v_q & bus.rsp_ready_i;
  assign s2_free = ~s2_v_q | bus.rsp_ready_i;
  assign s1_adv  = s1_v_q & s2_free;
  assign s1_free = ~s1_v_q | s2_free;
  assign s1_err  = (s1_instr_q[6:0] != OP_REG) && (s1_instr_q[6:0] != OP_IMM);

  // Round-robin search: indices >= ptr first, then wrap to those below ptr
  always_comb begin
    found     = 1'b0;
    gnt       = '0;
    ready     = '0;
    sel_instr = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid_i[i] && (IDW'(i) >= ptr_q)) begin
        found = 1'b1;
        gnt   = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid_i[i] && (IDW'(i) < ptr_q)) begin
        found = 1'b1;
        gnt   = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      ready[i] = found && (gnt == IDW'(i)) && s1_free && !rsn_i;
      if (gnt == IDW'(i)) begin
        sel_instr = bus.req_instr_i[IW*i +: IW];
        sel_a     = bus.req_a_i[DW*i +: DW];
        sel_b     = bus.req_b_i[DW*i +: DW];
      end
    end
  end

  assign accept          = found & s1_free & ~rsn_i;
  assign bus.req_ready_o = ready;

  // Next-state for S1, S2 and the pointer
  always_comb begin
    s1_v_d     = s1_v_q;
    s1_instr_d = s1_instr_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_v_d     = s2_v_q;
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    ptr_d      = ptr_q;

    if (accept) begin
      s1_v_d     = 1'b1;
      s1_instr_d = sel_instr;
      s1_a_d     = sel_a;
      s1_b_d     = sel_b;
      s1_id_d    = gnt;
      ptr_d      = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    if (s1_adv) begin
      s2_v_d    = 1'b1;
      s2_id_d   = s1_id_q;
      s2_err_d  = s1_err;
      s2_data_d = s1_err ? '0 : bus.alu_result_i;
    end else if (s2_adv) begin
      s2_v_d = 1'b0;
    end
  end

  // State registers; reset discards anything in flight
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      s1_v_q     <= 1'b0;
      s1_instr_q <= NOP_INSTR;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_v_q     <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      ptr_q      <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_instr_q <= s1_instr_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_v_q     <= s2_v_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.alu_instr_o = s1_instr_q;
  assign bus.alu_a_o     = s1_a_q;
  assign bus.alu_b_o     = s1_b_q;
  assign bus.rsp_valid_o = s2_v_q;
  assign bus.rsp_id_o    = s2_id_q;
  assign bus.rsp_data_o  = s2_data_q;
  assign bus.rsp_err_o   = s2_err_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vectors, scoreboard queue checked by a response monitor.
module tb_alu_share_arb;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] ADDI = 32'h00108093;
  localparam logic [31:0] LOAD = 32'h00000003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst3;

  alu_share_arb_if #(.NREQ(2), .IDW(2)) b2();
  alu_share_arb_if #(.NREQ(3), .IDW(2)) b3();

  alu_share_arb #(.NREQ(2), .IDW(2)) dut2 (.clk_i(clk), .rsn_i(rst2), .bus(b2));
  alu_share_arb #(.NREQ(3), .IDW(2)) dut3 (.clk_i(clk), .rsn_i(rst3), .bus(b3));

  // Stand-in for int_alu: add / addi, junk for anything else
  function automatic logic [63:0] alu_model(input logic [31:0] ins, input logic [63:0] a,
                                            input logic [63:0] b);
    case (ins[6:0])
      7'b0110011: return a + b;
      7'b0010011: return a + {{52{ins[31]}}, ins[31:20]};
      default:    return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  assign b2.alu_result_i = alu_model(b2.alu_instr_o, b2.alu_a_o, b2.alu_b_o);
  assign b3.alu_result_i = alu_model(b3.alu_instr_o, b3.alu_a_o, b3.alu_b_o);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];

  task automatic push(input logic [1:0] id, input logic [63:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    q.push_back(e);
  endtask

  // Response monitor: pops on every handshake, checks hold-stability under backpressure
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;
  logic [3:0]  prev_ctl   = '0;
  always @(negedge clk) begin
    if (rst2) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", b2.rsp_data_o, prev_data);
        check("stall_ctl", {60'd0, b2.rsp_valid_o, b2.rsp_id_o, b2.rsp_err_o}, {60'd0, prev_ctl});
      end
      if (b2.rsp_valid_o && b2.rsp_ready_i) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got id %0d data %0h, expected no response",
                   b2.rsp_id_o, b2.rsp_data_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_id", 64'(b2.rsp_id_o), 64'(e.id));
          check("rsp_data", b2.rsp_data_o, e.data);
          check("rsp_err", 64'(b2.rsp_err_o), 64'(e.err));
        end
      end
      prev_stall <= b2.rsp_valid_o && !b2.rsp_ready_i;
      prev_data  <= b2.rsp_data_o;
      prev_ctl   <= {b2.rsp_valid_o, b2.rsp_id_o, b2.rsp_err_o};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] ins, input logic [63:0] a,
                         input logic [63:0] b);
    b2.req_instr_i[32*r +: 32] = ins;
    b2.req_a_i[64*r +: 64]     = a;
    b2.req_b_i[64*r +: 64]     = b;
  endtask

  task automatic drained(input string name);
    @(negedge clk);
    #1;
    check(name, 64'(q.size()), 64'd0);
  endtask

  logic [1:0]  rr_rdy[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0]  rr_id[4]  = '{2'd0, 2'd1, 2'd0, 2'd1};
  logic [63:0] rr_dat[4] = '{64'd3, 64'd6, 64'd7, 64'd10};

  initial begin
    rst2 = 1'b1;
    rst3 = 1'b1;
    b2.req_valid_i = 2'b01;
    b2.req_instr_i = '0;
    b2.req_a_i     = '0;
    b2.req_b_i     = '0;
    b2.rsp_ready_i = 1'b1;
    b3.req_valid_i = '0;
    b3.req_instr_i = '0;
    b3.req_a_i     = '0;
    b3.req_b_i     = '0;
    b3.rsp_ready_i = 1'b1;

    // Reset state
    step();
    step();
    check("rst_ready", 64'(b2.req_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(b2.rsp_valid_o), 64'd0);
    check("rst_rsp_id", 64'(b2.rsp_id_o), 64'd0);
    check("rst_rsp_data", b2.rsp_data_o, 64'd0);
    check("rst_rsp_err", 64'(b2.rsp_err_o), 64'd0);
    check("rst_alu_instr", 64'(b2.alu_instr_o), 64'h13);
    check("rst_alu_a", b2.alu_a_o, 64'd0);
    check("rst_alu_b", b2.alu_b_o, 64'd0);
    rst2 = 1'b0;
    b2.req_valid_i = 2'b00;
    step();

    // Single add from requester 0
    set_req(0, ADD, 64'd5, 64'd7);
    b2.req_valid_i = 2'b01;
    #1;
    check("t1_ready", 64'(b2.req_ready_o), 64'b01);
    push(2'd0, 64'd12, 1'b0);
    step();
    b2.req_valid_i = 2'b00;
    check("t1_lat1", 64'(b2.rsp_valid_o), 64'd0);
    step();
    check("t1_lat2", 64'(b2.rsp_valid_o), 64'd1);
    drained("t1_drain");
    step();

    // Round-robin from a fresh pointer
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, ADD, 64'(2 * i), 64'd3);
      set_req(1, ADD, 64'(2 * i + 1), 64'd3);
      b2.req_valid_i = 2'b11;
      #1;
      check("t2_grant", 64'(b2.req_ready_o), 64'(rr_rdy[i]));
      push(rr_id[i], rr_dat[i], 1'b0);
      step();
    end
    b2.req_valid_i = 2'b00;
    step();
    drained("t2_drain");
    step();

    // Backpressure with requester 1 streaming addi
    b2.rsp_ready_i = 1'b0;
    b2.req_valid_i = 2'b10;
    set_req(1, ADDI, 64'd10, 64'd0);
    #1;
    check("t3_acc0", 64'(b2.req_ready_o), 64'b10);
    push(2'd1, 64'd11, 1'b0);
    step();
    set_req(1, ADDI, 64'd11, 64'd0);
    #1;
    check("t3_acc1", 64'(b2.req_ready_o), 64'b10);
    push(2'd1, 64'd12, 1'b0);
    step();
    set_req(1, ADDI, 64'd12, 64'd0);
    #1;
    check("t3_full", 64'(b2.req_ready_o), 64'b00);
    check("t3_hold_valid", 64'(b2.rsp_valid_o), 64'd1);
    check("t3_hold_data", b2.rsp_data_o, 64'd11);
    step();
    b2.rsp_ready_i = 1'b1;
    #1;
    check("t3_resume", 64'(b2.req_ready_o), 64'b10);
    push(2'd1, 64'd13, 1'b0);
    step();
    b2.req_valid_i = 2'b00;
    step();
    step();
    drained("t3_drain");
    step();

    // Unsupported opcode then a normal add
    b2.req_valid_i = 2'b01;
    set_req(0, LOAD, 64'd5, 64'd7);
    #1;
    check("t4_ready_ld", 64'(b2.req_ready_o), 64'b01);
    push(2'd0, 64'd0, 1'b1);
    step();
    set_req(0, ADD, 64'd20, 64'd22);
    #1;
    check("t4_ready_add", 64'(b2.req_ready_o), 64'b01);
    push(2'd0, 64'd42, 1'b0);
    step();
    b2.req_valid_i = 2'b00;
    check("t4_err", 64'(b2.rsp_err_o), 64'd1);
    check("t4_err_data", b2.rsp_data_o, 64'd0);
    step();
    step();
    drained("t4_drain");
    step();

    // Reset while S1 and S2 are both occupied
    b2.rsp_ready_i = 1'b0;
    b2.req_valid_i = 2'b01;
    set_req(0, ADD, 64'd1, 64'd1);
    step();
    step();
    #1;
    check("t5_full", 64'(b2.req_ready_o), 64'b00);
    rst2 = 1'b1;
    b2.req_valid_i = 2'b11;
    #1;
    check("t5_rst_ready", 64'(b2.req_ready_o), 64'b00);
    step();
    rst2 = 1'b0;
    b2.rsp_ready_i = 1'b1;
    check("t5_flush", 64'(b2.rsp_valid_o), 64'd0);
    set_req(1, ADD, 64'd100, 64'd1);
    set_req(0, ADD, 64'd1, 64'd1);
    #1;
    check("t5_ptr", 64'(b2.req_ready_o), 64'b01);
    push(2'd0, 64'd2, 1'b0);
    step();
    b2.req_valid_i = 2'b00;
    step();
    step();
    step();
    drained("t5_drain");

    // Pointer wrap with three requesters
    rst3 = 1'b0;
    b3.req_valid_i = 3'b100;
    #1;
    check("t6_first", 64'(b3.req_ready_o), 64'b100);
    step();
    b3.req_valid_i = 3'b111;
    #1;
    check("t6_g0", 64'(b3.req_ready_o), 64'b001);
    step();
    check("t6_g1", 64'(b3.req_ready_o), 64'b010);
    step();
    check("t6_g2", 64'(b3.req_ready_o), 64'b100);
    step();
    b3.req_valid_i = 3'b000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
